muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, running beside the ALU and owning the HI/LO registers.
- Its HI/LO outputs feed the 32-bit 2:1 result-select muxes ahead of EX/MEM, which choose between the ALU result and HI/LO for MFHI/MFLO.
- Runs MULT, MULTU, DIV and DIVU over 32 iterations and signals busy so hazard logic can stall the pipeline.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin an operation; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- flush  input  1  abort the in-flight operation
- mthi  input  1  write a to HI
- mtlo  input  1  write a to LO
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO have just been updated by an operation
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, hi=0, lo=0.
  - Internal counter, accumulators and operand latches cleared.
  - Applies immediately, including mid-operation.
- States: IDLE, RUN, FIX.
- IDLE with start=1 at edge T0:
  - Latch op, a and b.
  - For signed ops, latch |a| and |b| and record sign flags:
    - quotient sign = sign(a) XOR sign(b);
    - remainder sign = sign(a).
  - counter=0; go to RUN; busy=1 from T0.
- RUN: one iteration per edge; after the iteration at counter=WIDTH-1, go to FIX. RUN lasts exactly WIDTH edges.
  - Multiply: shift-add. 2*WIDTH accumulator; add multiplicand when the current multiplier LSB=1, then shift right.
  - Divide: restoring. Shift remainder left, bringing in the next dividend bit. Subtract divisor. If non-negative, keep the result and set the quotient bit to 1; otherwise restore and set it to 0.
- FIX (edge T(WIDTH+1)):
  - Apply two's-complement sign correction.
  - Write HI/LO:
    - Multiply: hi=product[2W-1:W], lo=product[W-1:0].
    - Divide: lo=quotient, hi=remainder.
  - Go to IDLE.
  - done=1 and busy=0 during the following cycle, so done, busy=0 and the new hi/lo become visible together after edge 33 (WIDTH=32). done is low in every other cycle.
- Divide by zero (b=0, signed or unsigned):
  - The iteration still runs the full WIDTH cycles.
  - Result forced to hi=a (original, uncorrected), lo=all-ones.
- Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF): lo=0x80000000, hi=0. This falls out of the abs/negate arithmetic in WIDTH bits.
- Truncated division: quotient rounds toward zero; remainder takes the dividend's sign.
- start while busy is ignored; no queueing.
- mthi/mtlo:
  - Honoured only in IDLE, with hi/lo updated at the next edge.
  - If start=1 in the same cycle, start wins and mthi/mtlo are dropped.
  - Ignored while busy.
  - mthi and mtlo together write a to both registers.
- flush:
  - In RUN or FIX: return to IDLE at the next edge; busy=0; done stays 0; hi/lo unchanged.
  - flush in IDLE has no effect; flush with start in IDLE blocks the start.
- hi/lo change only on FIX, mthi/mtlo or reset.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at T0 -> busy=1 for cycles 0..32; done=1 only in cycle 33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Then MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5 b=0 -> after 33 cycles hi=5, lo=0xFFFFFFFF, done pulses once.
- Preload: mthi a=0x1234 then mtlo a=0x5678 in IDLE. Start MULT, assert flush at cycle 10 -> busy=0 at cycle 11, done never asserts, hi=0x1234, lo=0x5678. A second start pulsed at cycle 5 (while busy) -> no effect.
- Drive rst_n=0 asynchronously at cycle 20 of a DIV -> busy, done, hi, lo go to 0 without waiting for a clock edge. After release, a new MULTU 3×4 -> lo=12, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU beside the ALU, owner of HI/LO.
// Operands are reduced to magnitudes at start, iterated unsigned for WIDTH
// cycles in RUN, then sign-corrected and written to HI/LO in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;      // original dividend, returned on divide by zero
  logic [WIDTH-1:0]   r_opnd;   // |multiplicand| or |divisor|
  logic [2*WIDTH:0]   r_acc;    // {upper W+1 bits, lower W bits}
  logic               r_qneg, r_rneg, r_dvz, r_done;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_go, w_sgn, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_abs, w_b_abs;
  logic [WIDTH:0]     w_mul_sum, w_rem_sh, w_diff;
  logic [2*WIDTH:0]   w_mul_next, w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_hi_res, w_lo_res;

  assign w_go    = (r_state == S_IDLE) && start && !flush;
  assign w_sgn   = ~op[0];
  assign w_a_neg = w_sgn & a[WIDTH-1];
  assign w_b_neg = w_sgn & b[WIDTH-1];
  assign w_a_abs = w_a_neg ? -a : a;
  assign w_b_abs = w_b_neg ? -b : b;

  // Shift-add step: conditionally add multiplicand to upper half, shift right.
  assign w_mul_sum  = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: remainder in upper bits, dividend/quotient in lower.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh, r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff,   r_acc[WIDTH-2:0], 1'b1};

  // Sign correction and result selection for the FIX write.
  assign w_prod = r_qneg ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
  assign w_quo  = r_qneg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_rneg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // HI/LO values written in FIX; divide by zero overrides the arithmetic result.
  always_comb begin
    w_hi_res = w_prod[2*WIDTH-1:WIDTH];
    w_lo_res = w_prod[WIDTH-1:0];
    if (r_op[1]) begin
      if (r_dvz) begin
        w_hi_res = r_a;
        w_lo_res = '1;
      end else begin
        w_hi_res = w_rem;
        w_lo_res = w_quo;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; flush aborts RUN/FIX and blocks a start in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_go) w_next = S_RUN;
      S_RUN:  if (flush) w_next = S_IDLE;
              else if (r_cnt == LAST) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, HI/LO writes and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_op   <= '0;
      r_a    <= '0;
      r_opnd <= '0;
      r_acc  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dvz  <= 1'b0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_op   <= op;
            r_a    <= a;
            r_cnt  <= '0;
            r_qneg <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
            r_dvz  <= op[1] && (b == '0);
            r_opnd <= op[1] ? w_b_abs : w_a_abs;
            r_acc  <= {{(WIDTH+1){1'b0}}, (op[1] ? w_a_abs : w_b_abs)};
          end else if (!start) begin
            if (mthi) r_hi <= a;
            if (mtlo) r_lo <= a;
          end
        end
        S_RUN: begin
          if (!flush) begin
            r_acc <= r_op[1] ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_FIX: begin
          if (!flush) begin
            r_hi   <= w_hi_res;
            r_lo   <= w_lo_res;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
